code_programmer: RTL

- Writer side of the safe-lock password path: lets the user replace the stored 4-bit combination using the same switches and active-low push-button style as the lock checker.
- Holds the combination register that the checker compares against.
- Sequence: authenticate with the old code, enter the new code, confirm it. Only then does the stored code change.
- Active-low LEDs report busy, success and error. Repeated authentication failures cause a timed lockout.

---
 rtl/code_programmer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/code_programmer.sv
// Writer side of the safe-lock path: authenticates the old code, takes a new code,
// confirms it and only then updates the combination register fed to the checker.
module code_programmer #(
    parameter logic [3:0] DEFAULT_CODE   = 4'b1111,
    parameter int          BLINK_CYCLES   = 50000000,
    parameter int          TIMEOUT_CYCLES = 500000000,
    parameter int          LOCK_CYCLES    = 1000000000,
    parameter int          MAX_FAILS      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_set_n,
    input  logic       btn_clr_n,
    output logic [3:0] code_out,
    output logic       code_valid,
    output logic       led_busy,
    output logic       led_ok,
    output logic       led_err
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_NEW     = 2'd1;
    localparam logic [1:0] S_CONFIRM = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);

    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LAST    = FW'(MAX_FAILS - 1);

    logic [3:0]    sw_s1, sw_s;
    logic          set_s1, set_s2, set_s3;
    logic          clr_s1, clr_s2, clr_s3;
    logic          press_set, press_clr;

    logic [1:0]    state;
    logic [3:0]    tmp_code;
    logic [FW-1:0] fail_cnt;
    logic [TW-1:0] to_cnt;
    logic [LW-1:0] lock_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_ok, blink_err;

    // Released buttons read as 1, so a press is the 1->0 step between s3 and s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1  <= 4'b1111;
            sw_s   <= 4'b1111;
            set_s1 <= 1'b1;
            set_s2 <= 1'b1;
            set_s3 <= 1'b1;
            clr_s1 <= 1'b1;
            clr_s2 <= 1'b1;
            clr_s3 <= 1'b1;
        end else begin
            sw_s1  <= sw;
            sw_s   <= sw_s1;
            set_s1 <= btn_set_n;
            set_s2 <= set_s1;
            set_s3 <= set_s2;
            clr_s1 <= btn_clr_n;
            clr_s2 <= clr_s1;
            clr_s3 <= clr_s2;
        end
    end

    assign press_set = set_s3 & ~set_s2;
    assign press_clr = clr_s3 & ~clr_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            code_out   <= DEFAULT_CODE;
            code_valid <= 1'b0;
            tmp_code   <= 4'b0000;
            fail_cnt   <= '0;
            to_cnt     <= '0;
            lock_cnt   <= '0;
            blink_cnt  <= '0;
            blink_ok   <= 1'b0;
            blink_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (blink_ok || blink_err) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_ok  <= 1'b0;
                    blink_err <= 1'b0;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
            // Later assignments below override the blink countdown when an event fires.
            case (state)
                S_IDLE: begin
                    if (press_set) begin
                        if (sw_s == code_out) begin
                            state    <= S_NEW;
                            fail_cnt <= '0;
                            to_cnt   <= '0;
                        end else if (fail_cnt == FAIL_LAST) begin
                            state     <= S_LOCKED;
                            fail_cnt  <= '0;
                            lock_cnt  <= '0;
                            blink_ok  <= 1'b0;
                            blink_err <= 1'b0;
                            blink_cnt <= '0;
                        end else begin
                            fail_cnt  <= fail_cnt + FW'(1);
                            blink_ok  <= 1'b0;
                            blink_err <= 1'b1;
                            blink_cnt <= '0;
                        end
                    end
                end
                S_NEW, S_CONFIRM: begin
                    if (press_clr) begin
                        state <= S_IDLE;
                    end else if (press_set && state == S_NEW) begin
                        tmp_code <= sw_s;
                        state    <= S_CONFIRM;
                        to_cnt   <= '0;
                    end else if (press_set) begin
                        state     <= S_IDLE;
                        blink_cnt <= '0;
                        if (sw_s == tmp_code) begin
                            code_out   <= tmp_code;
                            code_valid <= 1'b1;
                            blink_ok   <= 1'b1;
                            blink_err  <= 1'b0;
                        end else begin
                            blink_ok  <= 1'b0;
                            blink_err <= 1'b1;
                        end
                    end else if (to_cnt == TIMEOUT_LAST) begin
                        state     <= S_IDLE;
                        blink_ok  <= 1'b0;
                        blink_err <= 1'b1;
                        blink_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
            endcase
        end
    end

    assign led_busy = !(state == S_NEW || state == S_CONFIRM);
    assign led_ok   = !blink_ok;
    assign led_err  = !(blink_err || state == S_LOCKED);
endmodule
